// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: two one-entry slots (ALU, load) feeding one registered
// regfile write port, oldest slot first, round-robin on simultaneous arrival.
module regfile_writeback_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable,
    output logic                  busy
);

    logic                  alu_occ;
    logic [ADDR_WIDTH-1:0] alu_slot_addr;
    logic [DATA_WIDTH-1:0] alu_slot_data;
    logic                  load_occ;
    logic [ADDR_WIDTH-1:0] load_slot_addr;
    logic [DATA_WIDTH-1:0] load_slot_data;
    logic                  load_older;
    logic                  tie;
    logic                  rr;

    logic pick_load;
    logic grant_alu;
    logic grant_load;
    logic alu_hs;
    logic load_hs;

    // Age decides unless both slots filled on the same edge; then rr decides.
    assign pick_load  = tie ? rr : load_older;
    assign grant_alu  = alu_occ & (!load_occ | !pick_load);
    assign grant_load = load_occ & (!alu_occ | pick_load);

    assign alu_ready  = !RESET & (!alu_occ | grant_alu);
    assign load_ready = !RESET & (!load_occ | grant_load);
    assign alu_hs     = alu_valid & alu_ready;
    assign load_hs    = load_valid & load_ready;

    assign busy = alu_occ | load_occ | write_enable;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            alu_occ        <= 1'b0;
            alu_slot_addr  <= '0;
            alu_slot_data  <= '0;
            load_occ       <= 1'b0;
            load_slot_addr <= '0;
            load_slot_data <= '0;
            load_older     <= 1'b0;
            tie            <= 1'b0;
            rr             <= 1'b0;
            write_enable   <= 1'b0;
            write_addr     <= '0;
            write_data     <= '0;
        end else begin
            if (alu_hs) begin
                alu_occ       <= 1'b1;
                alu_slot_addr <= alu_addr;
                alu_slot_data <= alu_data;
            end else if (grant_alu) begin
                alu_occ <= 1'b0;
            end

            if (load_hs) begin
                load_occ       <= 1'b1;
                load_slot_addr <= load_addr;
                load_slot_data <= load_data;
            end else if (grant_load) begin
                load_occ <= 1'b0;
            end

            // The slot filled alone this edge is the younger one.
            if (alu_hs && load_hs) begin
                tie <= 1'b1;
            end else if (alu_hs) begin
                tie        <= 1'b0;
                load_older <= 1'b1;
            end else if (load_hs) begin
                tie        <= 1'b0;
                load_older <= 1'b0;
            end

            if (alu_occ && load_occ && tie) begin
                rr <= !rr;
            end

            write_enable <= grant_alu | grant_load;
            if (grant_alu) begin
                write_addr <= alu_slot_addr;
                write_data <= alu_slot_data;
            end else if (grant_load) begin
                write_addr <= load_slot_addr;
                write_data <= load_slot_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: timestamped-slot reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_writeback_arbiter;

    localparam int AW = 2;
    localparam int DW = 4;

    logic          CLK;
    logic          RESET;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          write_enable;
    logic          busy;

    regfile_writeback_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_enable (write_enable),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;
    bit run     = 1'b0;

    // Reference model: each slot remembers the cycle it was filled.
    int            cyc = 0;
    bit            m_occ  [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    int            m_ts   [2];
    bit            m_rr    = 1'b0;
    bit            m_we    = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rf [4];
    logic [DW-1:0] d_rf [4];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        if (m_occ[0] && m_occ[1]) begin
            if (m_ts[0] < m_ts[1]) return 0;
            if (m_ts[1] < m_ts[0]) return 1;
            return m_rr ? 1 : 0;
        end
        if (m_occ[0]) return 0;
        if (m_occ[1]) return 1;
        return -1;
    endfunction

    function automatic bit m_ready(input int p);
        return !RESET && (!m_occ[p] || m_grant() == p);
    endfunction

    always @(posedge CLK) begin : mdl
        int g;
        bit h0;
        bit h1;
        bit was_tie;
        g  = m_grant();
        h0 = alu_valid && m_ready(0);
        h1 = load_valid && m_ready(1);
        was_tie = m_occ[0] && m_occ[1] && m_ts[0] == m_ts[1];
        if (RESET) begin
            m_occ[0] = 0;
            m_occ[1] = 0;
            m_rr     = 0;
            m_we     = 0;
            m_waddr  = '0;
            m_wdata  = '0;
        end else begin
            if (g >= 0) begin
                m_we    = 1;
                m_waddr = m_addr[g];
                m_wdata = m_data[g];
                m_occ[g] = 0;
                if (was_tie) m_rr = !m_rr;
            end else begin
                m_we = 0;
            end
            if (h0) begin
                m_occ[0] = 1; m_addr[0] = alu_addr;
                m_data[0] = alu_data; m_ts[0] = cyc;
            end
            if (h1) begin
                m_occ[1] = 1; m_addr[1] = load_addr;
                m_data[1] = load_data; m_ts[1] = cyc;
            end
        end
        cyc++;
    end

    always @(negedge CLK) begin
        if (run) begin
            chk("alu_ready", alu_ready, m_ready(0));
            chk("load_ready", load_ready, m_ready(1));
            chk("write_enable", write_enable, m_we);
            chk("write_addr", write_addr, m_waddr);
            chk("write_data", write_data, m_wdata);
            chk("busy", busy, m_occ[0] | m_occ[1] | m_we);
            if (m_we) m_rf[m_waddr] = m_wdata;
            if (write_enable) d_rf[write_addr] = write_data;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        bit a_pend;
        bit l_pend;
        bit ra;
        bit rl;
        for (int i = 0; i < 4; i++) begin
            m_rf[i] = '0;
            d_rf[i] = '0;
        end
        m_occ[0] = 0; m_occ[1] = 0;
        m_ts[0] = 0;  m_ts[1] = 0;
        m_addr[0] = '0; m_addr[1] = '0;
        m_data[0] = '0; m_data[1] = '0;
        RESET = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        load_valid = 1'b0; load_addr = '0; load_data = '0;
        tick();
        run = 1'b1;

        // Request held during reset must be ignored.
        alu_valid = 1'b1; alu_addr = 2'd1; alu_data = 4'hF;
        repeat (3) begin
            tick();
            chk("rst_alu_ready", alu_ready, 0);
        end
        RESET = 1'b0; alu_valid = 1'b0;
        #1;
        chk("rst_we", write_enable, 0);
        chk("rst_waddr", write_addr, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_busy", busy, 0);
        repeat (2) begin
            tick();
            chk("rst_no_write", write_enable, 0);
        end

        // Single ALU write.
        alu_valid = 1'b1; alu_addr = 2'd2; alu_data = 4'hA;
        #1 chk("single_ready", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("single_k1_we", write_enable, 0);
        tick();
        chk("single_k2_we", write_enable, 1);
        chk("single_k2_addr", write_addr, 2);
        chk("single_k2_data", write_data, 4'hA);
        tick();
        chk("single_k3_we", write_enable, 0);
        chk("single_idle_busy", busy, 0);

        // ALU streaming alone.
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_addr = AW'(i); alu_data = DW'(i + 1);
            #1 chk("stream_ready", alu_ready, 1);
            tick();
            if (i > 0) begin
                chk("stream_we", write_enable, 1);
                chk("stream_data", write_data, i);
            end
        end
        alu_valid = 1'b0;
        tick();
        chk("stream_we", write_enable, 1);
        chk("stream_data", write_data, 4);
        tick();
        chk("stream_end_we", write_enable, 0);

        // First tie: ALU wins, then load.
        alu_valid = 1'b1; alu_addr = 2'd1; alu_data = 4'h3;
        load_valid = 1'b1; load_addr = 2'd1; load_data = 4'h5;
        tick();
        alu_valid = 1'b0; load_valid = 1'b0;
        tick();
        chk("tie1_first", write_data, 4'h3);
        tick();
        chk("tie1_second", write_data, 4'h5);
        chk("tie1_addr", write_addr, 1);
        tick();
        chk("tie1_rf1", d_rf[1], 4'h5);

        // Second tie: rr flipped, load wins.
        alu_valid = 1'b1; alu_addr = 2'd0; alu_data = 4'h6;
        load_valid = 1'b1; load_addr = 2'd0; load_data = 4'h7;
        tick();
        alu_valid = 1'b0; load_valid = 1'b0;
        tick();
        chk("tie2_first", write_data, 4'h7);
        tick();
        chk("tie2_second", write_data, 4'h6);
        tick();

        // Age priority: ALU refilled while load waits becomes younger.
        alu_valid = 1'b1; alu_addr = 2'd3; alu_data = 4'h9;
        load_valid = 1'b1; load_addr = 2'd3; load_data = 4'h7;
        tick();
        load_valid = 1'b0; alu_data = 4'hB;
        #1;
        chk("age_alu_ready", alu_ready, 1);
        chk("age_load_ready", load_ready, 0);
        tick();
        chk("age_w9", write_data, 4'h9);
        alu_data = 4'hC;
        #1 chk("age_blocked", alu_ready, 0);
        tick();
        chk("age_w7", write_data, 4'h7);
        chk("age_unblocked", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("age_wB", write_data, 4'hB);
        tick();
        chk("age_wC", write_data, 4'hC);
        tick();
        chk("age_rf3", d_rf[3], 4'hC);

        // Reset with both slots occupied.
        alu_valid = 1'b1; alu_addr = 2'd2; alu_data = 4'h1;
        load_valid = 1'b1; load_addr = 2'd1; load_data = 4'h2;
        tick();
        RESET = 1'b1; alu_valid = 1'b0; load_valid = 1'b0;
        #1;
        chk("mid_rst_alu_ready", alu_ready, 0);
        chk("mid_rst_load_ready", load_ready, 0);
        tick();
        chk("mid_rst_we", write_enable, 0);
        chk("mid_rst_busy", busy, 0);
        RESET = 1'b0;
        #1;
        chk("mid_rel_alu_ready", alu_ready, 1);
        chk("mid_rel_load_ready", load_ready, 1);
        tick();
        chk("mid_rel_we", write_enable, 0);
        chk("mid_rel_busy", busy, 0);

        // Randomized traffic with backpressure and occasional reset.
        a_pend = 0;
        l_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!a_pend) begin
                alu_valid = ($urandom % 4) != 0;
                alu_addr  = AW'($urandom);
                alu_data  = DW'($urandom);
            end
            if (!l_pend) begin
                load_valid = ($urandom % 3) != 0;
                load_addr  = AW'($urandom);
                load_data  = DW'($urandom);
            end
            RESET = ($urandom % 64) == 0;
            #1;
            ra = alu_ready;
            rl = load_ready;
            tick();
            a_pend = alu_valid && !ra;
            l_pend = load_valid && !rl;
        end
        RESET = 1'b0; alu_valid = 1'b0; load_valid = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 4; i++) begin
            chk("final_rf", d_rf[i], m_rf[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
